// File: rtl/door_ctrl_fsm.sv
// Elevator door controller: open/dwell/close sequencing with limit switches, motion timeout,
// reopen limiting with forced nudge close (enabled by DOOR_NUDGE_EN), and a latched fault state.
module door_ctrl_fsm #(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned DWELL_S     = 15,
  parameter int unsigned MOTION_TO_S = 10,
  parameter int unsigned MAX_REOPEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       door_req,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       door_sensor,
  input  logic       open_lim,
  input  logic       closed_lim,
  output logic       motor_open,
  output logic       motor_close,
  output logic       nudge,
  output logic       door_closed,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_OPENING = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSING = 3'd3,
    S_NUDGE   = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam int unsigned PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0] DWELL_LD    = 8'(DWELL_S);
  localparam logic [7:0] MOTION_LAST = 8'(MOTION_TO_S - 1);
  localparam logic [3:0] REOPEN_LIM  = 4'(MAX_REOPEN);

  state_t        cur, nxt;
  logic [PW-1:0] presc;
  logic [7:0]    dwell;
  logic [7:0]    motion_tmr;
  logic [3:0]    reopen_cnt;
  logic          req_q;
  logic          tick;
  logic          motion_to;
  logic          load_dwell;
  logic          reopen;
  logic          nudge_sel;

  assign tick      = (presc == PRESC_MAX);
  // Timeout fires on the tick that would bring the timer up to MOTION_TO_S.
  assign motion_to = tick && (motion_tmr == MOTION_LAST);

`ifdef DOOR_NUDGE_EN
  assign nudge_sel = (reopen_cnt >= REOPEN_LIM);
`else
  assign nudge_sel = 1'b0;
`endif

  always_comb begin
    nxt        = cur;
    load_dwell = 1'b0;
    reopen     = 1'b0;
    case (cur)
      S_CLOSED: begin
        if (door_req && ((door_req && !req_q) || open_btn)) nxt = S_OPENING;
      end
      S_OPENING: begin
        if (open_lim) begin
          nxt        = S_OPEN;
          load_dwell = 1'b1;
        end else if (motion_to) begin
          nxt = S_FAULT;
        end
      end
      S_OPEN: begin
        if (door_sensor || open_btn)       load_dwell = 1'b1;
        else if (close_btn)                nxt = S_CLOSING;
        else if (tick && (dwell <= 8'd1))  nxt = S_CLOSING;
      end
      S_CLOSING: begin
        if (door_sensor || open_btn) begin
          reopen = 1'b1;
          nxt    = nudge_sel ? S_NUDGE : S_OPENING;
        end else if (closed_lim) begin
          nxt = S_CLOSED;
        end else if (motion_to) begin
          nxt = S_FAULT;
        end
      end
      S_NUDGE: begin
        if (closed_lim)     nxt = S_CLOSED;
        else if (motion_to) nxt = S_FAULT;
      end
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur   <= S_CLOSED;
      req_q <= 1'b0;
    end else begin
      cur   <= nxt;
      req_q <= door_req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if ((nxt != cur) || load_dwell || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell <= 8'd0;
    end else if (load_dwell) begin
      dwell <= DWELL_LD;
    end else if ((cur == S_OPEN) && tick && (dwell != 8'd0)) begin
      dwell <= dwell - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      motion_tmr <= 8'd0;
    end else if (nxt != cur) begin
      motion_tmr <= 8'd0;
    end else if (tick && (motion_tmr != 8'hFF) &&
                 ((cur == S_OPENING) || (cur == S_CLOSING) || (cur == S_NUDGE))) begin
      motion_tmr <= motion_tmr + 8'd1;
    end
  end

  // Saturates just past the limit; only the comparison against MAX_REOPEN matters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reopen_cnt <= 4'd0;
    end else if ((nxt == S_CLOSED) && (cur != S_CLOSED)) begin
      reopen_cnt <= 4'd0;
    end else if (reopen && (reopen_cnt != 4'hF) && (reopen_cnt <= REOPEN_LIM)) begin
      reopen_cnt <= reopen_cnt + 4'd1;
    end
  end

  assign motor_open  = (cur == S_OPENING);
  assign motor_close = (cur == S_CLOSING) || (cur == S_NUDGE);
  assign fault       = (cur == S_FAULT);
  assign door_closed = (cur == S_CLOSED) && closed_lim;
  assign state       = cur;

`ifdef DOOR_NUDGE_EN
  assign nudge = (cur == S_NUDGE);
`else
  assign nudge = 1'b0;
`endif

endmodule

// File: doc/door_ctrl_fsm.md
# door_ctrl_fsm

Parametrised elevator door controller: a state machine that drives the door motor open and closed, holds the door open for a programmable dwell time, and reopens on obstruction or button press. It adds limit-switch feedback, a motion timeout, a reopen limit with a forced nudge-close, and a latched fault state. It sits between the car controller, which asserts `door_req` while the car is stopped at a floor, and the door motor driver.

## Interface
- `TICK_DIV`, 100000000: clock cycles per one-second tick (≥2).
- `DWELL_S`, 15: dwell time in ticks (1..255).
- `MOTION_TO_S`, 10: maximum ticks for an open or close stroke before fault (1..255).
- `MAX_REOPEN`, 3: reopens allowed per close attempt before nudge (1..15).

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `door_req` in 1: car stopped at floor; doors may operate.
- `open_btn` in 1: cab door-open button, level.
- `close_btn` in 1: cab door-close button, level.
- `door_sensor` in 1: obstruction sensor, 1 = blocked.
- `open_lim` in 1: fully-open limit switch.
- `closed_lim` in 1: fully-closed limit switch.
- `motor_open` out 1: drive door open.
- `motor_close` out 1: drive door closed.
- `nudge` out 1: slow forced close with buzzer.
- `door_closed` out 1: door closed and locked; car may move.
- `fault` out 1: door fault latched.
- `state` out 3: current state code.

## Operation
- States: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, NUDGE=4, FAULT=5. Codes 6 and 7 are illegal and recover to FAULT.
- Reset: state CLOSED; all counters 0; `motor_open`, `motor_close`, `nudge`, and `fault` are 0; `door_closed` = `closed_lim`.
- Moore outputs decoded from the state register:
  - `motor_open` = OPENING.
  - `motor_close` = CLOSING|NUDGE.
  - `nudge` = NUDGE.
  - `fault` = FAULT.
  - `door_closed` = CLOSED & `closed_lim`.
- Prescaler counts 0..TICK_DIV-1 and pulses `tick` at TICK_DIV-1. It clears on every state change and on every dwell reload.
- The 8-bit dwell counter loads DWELL_S and decrements on `tick`.
- The 8-bit motion timer clears on state entry and increments on `tick` in OPENING, CLOSING and NUDGE.
- The 4-bit reopen counter clears on entry to CLOSED.
- CLOSED → OPENING when `door_req` & (rising edge of `door_req` | `open_btn`). Otherwise the state holds. `door_sensor` is ignored in CLOSED.
- OPENING:
  - `open_lim` → OPEN and load dwell.
  - Otherwise, motion timer == MOTION_TO_S → FAULT.
- OPEN:
  - `door_sensor` | `open_btn` reloads dwell and holds the state.
  - Else `close_btn` → CLOSING.
  - Else dwell reaches 0 on a `tick` → CLOSING.
- CLOSING:
  - `door_sensor` | `open_btn` → reopen. The reopen counter increments and the state goes to OPENING, or to NUDGE (see Configuration).
  - Else `closed_lim` → CLOSED.
  - Else timeout → FAULT.
- NUDGE: `door_sensor` and `open_btn` are ignored. `closed_lim` → CLOSED; timeout → FAULT.
- FAULT: absorbing; exits only on `reset`.
- `door_req` deassertion is ignored outside CLOSED.

## Timing
- Inputs are sampled at edge N, the state updates at edge N, and outputs are valid after edge N. This gives 1-cycle latency from condition to output.
- Dwell: entering OPEN at edge E with no holds gives CLOSING at edge E + DWELL_S·TICK_DIV.
- A hold at edge H restarts the full dwell: CLOSING at H + DWELL_S·TICK_DIV.
- Motion timeout: FAULT at edge E + MOTION_TO_S·TICK_DIV after stroke entry.
- Simultaneous events:
  - A limit switch beats a same-cycle timeout.
  - Sensor/`open_btn` beats `closed_lim` in CLOSING (safety first).
  - Sensor beats `close_btn` in OPEN.
- Reset mid-stroke stops both motors asynchronously.

## Configuration
- `DOOR_NUDGE_EN` defined: the reopen that would make the reopen counter exceed MAX_REOPEN goes to NUDGE instead of OPENING.
- `DOOR_NUDGE_EN` undefined: reopens are unlimited, NUDGE is unreachable, and `nudge` is tied to 0.

## Test plan
All scenarios use TICK_DIV=4, DWELL_S=3, MOTION_TO_S=5, MAX_REOPEN=2.
- Assert `reset` mid-OPENING → `motor_open`=0 immediately; after release, `state`=0 and all outputs 0.
- `door_req` rises → `motor_open`=1 next cycle; `open_lim` at edge E → `state`=2; `state`=3 at edge E+12; `closed_lim` → `state`=0, `door_closed`=1.
- In OPEN, hold `door_sensor`=1 for 20 cycles ending at edge H → `state` stays 2 throughout; CLOSING at H+12.
- `DOOR_NUDGE_EN` defined: pulse `door_sensor` in CLOSING three times → first two go to OPENING, third to NUDGE with `nudge`=1. In NUDGE, `door_sensor` is ignored; `closed_lim` → CLOSED and the reopen counter reads 0.
- OPENING with `open_lim` held 0 → `fault`=1, `state`=5 at entry+20 cycles, motors 0; remains until `reset`.
- OPEN with `close_btn`=1, `door_sensor`=0 → `state`=3 next edge; same with `door_sensor`=1 → `state` stays 2.
